// File: rtl/simd_pe_mac_lane_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simd_pe_mac_lane_if : shared load/read/control bus of one SIMD lane
// Revision: 1.0
// ---------------------------------------------------------------------------
interface simd_pe_mac_lane_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ACC_W  = 2 * DATA_W + ADDR_W;

  logic              wr_en;
  logic [1:0]        wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ACC_W-1:0]  acc_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, mode, len, rd_addr,
    input  rd_data, acc_out, busy, done, err
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, mode, len, rd_addr,
    output rd_data, acc_out, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/simd_pe_mac_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simd_pe_mac_lane : one SIMD lane with A/B/C banks running DOT, VADD, VMUL
// Revision: 1.0
// ---------------------------------------------------------------------------
module simd_pe_mac_lane #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  simd_pe_mac_lane_if.slave        bus
);
  localparam int ADDR_W     = $clog2(DEPTH);
  localparam int LEN_W      = ADDR_W + 1;
  localparam int ACC_W      = 2 * DATA_W + ADDR_W;
  localparam int BANK_WORDS = 1 << ADDR_W;

  localparam logic [1:0] MODE_DOT  = 2'd0;
  localparam logic [1:0] MODE_VADD = 2'd1;
  localparam logic [1:0] MODE_VMUL = 2'd2;
  localparam logic [1:0] MODE_BAD  = 2'd3;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        mode_q;
  logic [LEN_W-1:0]  len_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0] rd_data_q;

  // Banks are sized to a power of two so any index value is in range
  logic [DATA_W-1:0] a_bank [BANK_WORDS];
  logic [DATA_W-1:0] b_bank [BANK_WORDS];
  logic [DATA_W-1:0] c_bank [BANK_WORDS];

  logic [DATA_W-1:0]          op_a;
  logic [DATA_W-1:0]          op_b;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          sum;
  logic [ACC_W-1:0]           prod_ext;
  logic                       start_legal;
  logic                       last_elem;

  assign op_a        = a_bank[idx];
  assign op_b        = b_bank[idx];
  assign prod        = $signed(op_a) * $signed(op_b);
  assign sum         = op_a + op_b;
  assign prod_ext    = {{ADDR_W{prod[2*DATA_W-1]}}, prod};
  assign start_legal = (bus.mode != MODE_BAD) && (bus.len != '0) &&
                       (bus.len <= LEN_W'(DEPTH));
  assign last_elem   = (LEN_W'(idx) == (len_q - LEN_W'(1)));

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= IDLE;
      idx       <= '0;
      mode_q    <= MODE_DOT;
      len_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      acc_q     <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < BANK_WORDS; i++) begin
        a_bank[i] <= '0;
        b_bank[i] <= '0;
        c_bank[i] <= '0;
      end
    end else begin
      // Non-blocking read returns the pre-write value on a same-edge C write
      rd_data_q <= c_bank[bus.rd_addr];

      case (state)
        IDLE: begin
          if (bus.wr_en) begin
            case (bus.wr_sel)
              SEL_A:   a_bank[bus.wr_addr] <= bus.wr_data;
              SEL_B:   b_bank[bus.wr_addr] <= bus.wr_data;
              SEL_C:   c_bank[bus.wr_addr] <= bus.wr_data;
              default: ;
            endcase
          end
          if (bus.start) begin
            if (start_legal) begin
              state  <= RUN;
              idx    <= '0;
              acc_q  <= '0;
              err_q  <= 1'b0;
              mode_q <= bus.mode;
              len_q  <= bus.len;
              busy_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        RUN: begin
          if (bus.wr_en) begin
            err_q <= 1'b1;
          end
          case (mode_q)
            MODE_DOT:  acc_q       <= acc_q + prod_ext;
            MODE_VADD: c_bank[idx] <= sum;
            MODE_VMUL: c_bank[idx] <= prod[DATA_W-1:0];
            default:   ;
          endcase
          if (last_elem) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end

        DONE: begin
          if (bus.wr_en) begin
            err_q <= 1'b1;
          end
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.acc_out = acc_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule
`default_nettype wire
